vga_pixel_fetch: RTL and testbench
==================================

# vga_pixel_fetch

Scan-out front end of the display path: generates VGA raster timing, reads one colour id per pixel from a double-buffered framebuffer, and presents that id, aligned with its sync and blank signals, to the colour palette. The palette turns the id into 10-bit R/G/B combinationally. Buffer swaps are requested by the renderer and committed only at frame boundaries, so no frame shows a partial swap.

## Interface

- H_ACTIVE, 640, visible pixels per line
- H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal porch and sync widths, in clocks
- V_ACTIVE, 480, visible lines
- V_FP, 10; V_SYNC, 2; V_BP, 33: vertical porch and sync widths, in lines
- NUMBER_COLORS, 4, palette entries; ID_W = max(1, $clog2(NUMBER_COLORS))
- SCALE_SHIFT, 1, framebuffer downscale; FB_W = H_ACTIVE>>SCALE_SHIFT, FB_H = V_ACTIVE>>SCALE_SHIFT
- FB_ADDR_W, 17, address bits per buffer; must satisfy 2^FB_ADDR_W ≥ FB_W·FB_H

Ports:
- clk  in  1  pixel clock (25 MHz for the defaults)
- rst  in  1  reset; asynchronous, active-high
- fb_rd_en  out  1  framebuffer read strobe
- fb_addr  out  FB_ADDR_W+1  {fb_sel, pixel address}
- fb_data  in  ID_W  read data, valid one clock after fb_addr/fb_rd_en
- frame_swap_req  in  1  level request to swap display buffer
- frame_swap_ack  out  1  one-clock pulse; swap committed
- fb_sel  out  1  buffer currently displayed
- pixel_id  out  ID_W  colour id to palette
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- VGA_BLANK_N  out  1  high during the visible region
- VGA_SYNC_N  out  1  tied 0

## Operation

- **Counters.**
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - v_cnt runs 0..V_TOTAL-1 (525) and increments when h_cnt wraps.
  - Both counters wrap to 0 together at the end of a frame.
- **Raw timing (stage 0).**
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_raw is low for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is low under the same rule, applied to v_cnt and the vertical parameters.
- **Stage 1 (registered).**
  - fb_rd_en = active.
  - fb_addr = {fb_sel, (v_cnt>>SCALE_SHIFT)·FB_W + (h_cnt>>SCALE_SHIFT)}, truncated to FB_ADDR_W bits.
  - When inactive, fb_addr holds its previous value.
  - The multiply uses a constant FB_W; strength-reduce to shifts and adds where possible.
- **Stage 2.** fb_data is returned by the RAM.
- **Stage 3 (registered outputs).**
  - pixel_id = delayed active ? fb_data : 0.
  - VGA_HS, VGA_VS and VGA_BLANK_N are the stage-0 values delayed through three registers.
- **Swap handshake.**
  - The swap point is the single clock where h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1.
  - If frame_swap_req is high at the swap point: fb_sel toggles and frame_swap_ack pulses high for exactly that next clock.
  - If frame_swap_req is low at the swap point: nothing happens.
  - The requester must hold req until it sees ack, then drop it within one frame. A req still high at the next swap point swaps again.
  - Dropping req before the swap point cancels the request.
  - fb_sel changes only at the swap point, so every line of a frame reads one buffer.

## Timing

- **Reset values (asynchronous):**
  - h_cnt = v_cnt = 0, fb_sel = 0, fb_rd_en = 0, fb_addr = 0.
  - frame_swap_ack = 0, pixel_id = 0.
  - VGA_HS = VGA_VS = 1, VGA_BLANK_N = 0, and all delay-pipe bits hold their inactive values.
- **Latency.**
  - Counter state at clock t appears on pixel_id, VGA_HS, VGA_VS and VGA_BLANK_N at t+3.
  - fb_addr is valid at t+1.
- **Alignment.** All four outputs change on the same edge. The palette's combinational RGB is therefore aligned with the syncs.
- **First visible pixel after reset** is pixel (0,0): VGA_BLANK_N rises on the 4th rising edge after rst deasserts.
- **Reset mid-frame.**
  - Immediate return to reset values.
  - The pipeline is flushed, with no stale ids.
  - The raster restarts at (0,0), and any pending swap is discarded.
- **Periods.**
  - Line period: H_TOTAL clocks, with HS low for H_SYNC clocks.
  - Frame period: H_TOTAL·V_TOTAL clocks (420000), with VS low for V_SYNC·H_TOTAL clocks.

## Test plan

- **Reset values.** Assert rst mid-line -> all outputs take their reset values within the same clock, with no clk edge needed. Release rst -> VGA_BLANK_N first rises 4 clocks later.
- **Line timing.** Free-run the defaults.
  - VGA_HS falls 656+3 clocks after a line starts and stays low for 96 clocks.
  - The HS falling-edge period is 800 clocks.
  - VGA_BLANK_N is high for 640 clocks per visible line.
- **Frame timing.** VGA_VS falling edges are 420000 clocks apart, and VGA_VS is low for 1600 clocks. VGA_BLANK_N stays low for all of lines 480..524.
- **Address and data path.** Use SCALE_SHIFT=1 and a RAM model returning fb_data = address[ID_W-1:0].
  - Screen pixel (3,2) -> fb_addr = 321, which is 1·320+1.
  - pixel_id = 1 three clocks after (3,2) is counted.
  - pixel_id = 0 whenever VGA_BLANK_N = 0.
- **Swap handshake.**
  - Raise frame_swap_req mid-frame -> fb_sel toggles exactly at the frame wrap, with a one-clock frame_swap_ack; fb_addr MSB = 1 for the whole next frame.
  - Drop req before the wrap -> no swap and no ack.
- **Held request.** Hold frame_swap_req high for 3 frames -> 3 acks, with fb_sel reading 1, 0, 1.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module : vga_pixel_fetch
// Brief  : VGA raster timing and double-buffered framebuffer fetch feeding the palette
// Rev    : 1.0  initial release
// ============================================================================
module vga_pixel_fetch #(
   parameter  int H_ACTIVE      = 640,
   parameter  int H_FP          = 16,
   parameter  int H_SYNC        = 96,
   parameter  int H_BP          = 48,
   parameter  int V_ACTIVE      = 480,
   parameter  int V_FP          = 10,
   parameter  int V_SYNC        = 2,
   parameter  int V_BP          = 33,
   parameter  int NUMBER_COLORS = 4,
   parameter  int SCALE_SHIFT   = 1,
   parameter  int FB_ADDR_W     = 17,
   localparam int ID_W          = (NUMBER_COLORS > 2) ? $clog2(NUMBER_COLORS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 fb_rd_en,
   output logic [FB_ADDR_W:0]   fb_addr,
   input  logic [ID_W-1:0]      fb_data,
   input  logic                 frame_swap_req,
   output logic                 frame_swap_ack,
   output logic                 fb_sel,
   output logic [ID_W-1:0]      pixel_id,
   output logic                 VGA_HS,
   output logic                 VGA_VS,
   output logic                 VGA_BLANK_N,
   output logic                 VGA_SYNC_N
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);
   localparam int FB_W     = H_ACTIVE >> SCALE_SHIFT;
   localparam int MUL_BITS = (FB_ADDR_W < 32) ? FB_ADDR_W : 32;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [31:0]   FB_W_C = 32'(FB_W);

   // Row offset as a sum of shifted copies, one per set bit of the line width.
   function automatic logic [FB_ADDR_W-1:0] mul_fb_w(input logic [FB_ADDR_W-1:0] y);
      logic [FB_ADDR_W-1:0] acc;
      acc = '0;
      for (int b = 0; b < MUL_BITS; b++) begin
         if (FB_W_C[b]) acc = acc + (y << b);
      end
      return acc;
   endfunction

   logic [HW-1:0]        h_cnt_q, h_cnt_d;
   logic [VW-1:0]        v_cnt_q, v_cnt_d;
   logic                 fb_sel_q, fb_sel_d;
   logic                 ack_q, ack_d;
   logic                 rd_en_q, rd_en_d;
   logic [FB_ADDR_W:0]   addr_q, addr_d;
   logic                 act1_q, hs1_q, vs1_q;
   logic                 act2_q, hs2_q, vs2_q;
   logic [ID_W-1:0]      pix_q, pix_d;
   logic                 hs3_q, vs3_q, blank3_q;

   logic                 active, hs_raw, vs_raw, swap_pt;
   logic [FB_ADDR_W-1:0] pix_addr;

   always_comb begin
      active   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs_raw   = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
      vs_raw   = !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));
      swap_pt  = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
      pix_addr = mul_fb_w(FB_ADDR_W'(v_cnt_q >> SCALE_SHIFT))
               + FB_ADDR_W'(h_cnt_q >> SCALE_SHIFT);

      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end

      ack_d    = swap_pt && frame_swap_req;
      fb_sel_d = fb_sel_q ^ ack_d;
      rd_en_d  = active;
      addr_d   = active ? {fb_sel_q, pix_addr} : addr_q;
      // fb_data belongs to the address issued two clocks earlier, i.e. to stage 2
      pix_d    = act2_q ? fb_data : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q  <= '0;
         v_cnt_q  <= '0;
         fb_sel_q <= 1'b0;
         ack_q    <= 1'b0;
         rd_en_q  <= 1'b0;
         addr_q   <= '0;
         act1_q   <= 1'b0;
         hs1_q    <= 1'b1;
         vs1_q    <= 1'b1;
         act2_q   <= 1'b0;
         hs2_q    <= 1'b1;
         vs2_q    <= 1'b1;
         pix_q    <= '0;
         hs3_q    <= 1'b1;
         vs3_q    <= 1'b1;
         blank3_q <= 1'b0;
      end else begin
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         fb_sel_q <= fb_sel_d;
         ack_q    <= ack_d;
         rd_en_q  <= rd_en_d;
         addr_q   <= addr_d;
         act1_q   <= active;
         hs1_q    <= hs_raw;
         vs1_q    <= vs_raw;
         act2_q   <= act1_q;
         hs2_q    <= hs1_q;
         vs2_q    <= vs1_q;
         pix_q    <= pix_d;
         hs3_q    <= hs2_q;
         vs3_q    <= vs2_q;
         blank3_q <= act2_q;
      end
   end

   assign fb_rd_en       = rd_en_q;
   assign fb_addr        = addr_q;
   assign frame_swap_ack = ack_q;
   assign fb_sel         = fb_sel_q;
   assign pixel_id       = pix_q;
   assign VGA_HS         = hs3_q;
   assign VGA_VS         = vs3_q;
   assign VGA_BLANK_N    = blank3_q;
   assign VGA_SYNC_N     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`default_nettype none
// Bench for vga_pixel_fetch: a reduced raster compared every clock against an arithmetic
// raster model, plus a default-size instance for the reference pixel and sync positions.
module tb_vga_pixel_fetch;

   localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3, HT = HA + HFP + HSY + HBP;
   localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
   localparam int FT  = HT * VT;
   localparam int AW  = 5;
   localparam int IDW = 2;
   localparam int FBW = HA / 2;

   logic clk = 1'b0, rst = 1'b1, req = 1'b0;
   logic           fb_rd_en, ack, sel, hs, vs, blank, syncn;
   logic [AW:0]    fb_addr;
   logic [IDW-1:0] fb_data = '0, pix;

   logic        d_req = 1'b0;
   logic        d_rd_en, d_ack, d_sel, d_hs, d_vs, d_blank, d_syncn;
   logic [17:0] d_addr;
   logic [1:0]  d_data = '0, d_pix;

   int n_pass = 0, n_tot = 0;

   vga_pixel_fetch #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .NUMBER_COLORS(4), .SCALE_SHIFT(1), .FB_ADDR_W(AW)
   ) u_dut (
      .clk(clk), .rst(rst), .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_data(fb_data),
      .frame_swap_req(req), .frame_swap_ack(ack), .fb_sel(sel), .pixel_id(pix),
      .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank), .VGA_SYNC_N(syncn)
   );

   vga_pixel_fetch u_dut_def (
      .clk(clk), .rst(rst), .fb_rd_en(d_rd_en), .fb_addr(d_addr), .fb_data(d_data),
      .frame_swap_req(d_req), .frame_swap_ack(d_ack), .fb_sel(d_sel), .pixel_id(d_pix),
      .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_blank), .VGA_SYNC_N(d_syncn)
   );

   always #5 clk = ~clk;

   // Buffer contents differ between the two buffers so a wrong fb_sel shows up on pixel_id.
   function automatic logic [IDW-1:0] ram_val(input logic [AW:0] a);
      return a[IDW-1:0] ^ {IDW{a[AW]}};
   endfunction

   always @(posedge clk) begin
      fb_data <= ram_val(fb_addr);
      d_data  <= d_addr[1:0];
   end

   // Model: cyc = rising edges since reset release = raster index now on the counters.
   int cyc;
   bit fsel [0:255];
   bit exp_ack;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc     <= 0;
         exp_ack <= 1'b0;
         for (int i = 0; i < 256; i++) fsel[i] <= 1'b0;
      end else begin
         exp_ack <= ((cyc % FT) == FT - 1) && req;
         if ((cyc % FT) == FT - 1) fsel[((cyc / FT) + 1) % 256] <= fsel[(cyc / FT) % 256] ^ req;
         cyc <= cyc + 1;
      end
   end

   function automatic bit act_of(input int i);
      return ((i % HT) < HA) && (((i / HT) % VT) < VA);
   endfunction
   function automatic bit hs_of(input int i);
      return !(((i % HT) >= HA + HFP) && ((i % HT) < HA + HFP + HSY));
   endfunction
   function automatic bit vs_of(input int i);
      return !((((i / HT) % VT) >= VA + VFP) && (((i / HT) % VT) < VA + VFP + VSY));
   endfunction
   function automatic logic [AW:0] addr_of(input int i);
      logic [AW-1:0] off;
      off = AW'((((i / HT) % VT) / 2) * FBW + (i % HT) / 2);
      return {fsel[(i / FT) % 256], off};
   endfunction
   function automatic int last_active(input int j);
      int h, v, base;
      h = j % HT; v = (j / HT) % VT; base = j - (j % FT);
      if (v >= VA) return base + (VA - 1) * HT + HA - 1;
      if (h >= HA) return base + v * HT + HA - 1;
      return j;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, cyc, $time);
   endtask

   task automatic compare_cycle();
      int k, i, j;
      k = cyc; i = k - 3; j = k - 1;
      if (i < 0) begin
         check("VGA_BLANK_N", 32'(blank), 32'd0);
         check("VGA_HS", 32'(hs), 32'd1);
         check("VGA_VS", 32'(vs), 32'd1);
         check("pixel_id", 32'(pix), 32'd0);
      end else begin
         check("VGA_BLANK_N", 32'(blank), 32'(act_of(i)));
         check("VGA_HS", 32'(hs), 32'(hs_of(i)));
         check("VGA_VS", 32'(vs), 32'(vs_of(i)));
         check("pixel_id", 32'(pix), act_of(i) ? 32'(ram_val(addr_of(i))) : 32'd0);
      end
      if (j < 0) begin
         check("fb_rd_en", 32'(fb_rd_en), 32'd0);
         check("fb_addr", 32'(fb_addr), 32'd0);
      end else begin
         check("fb_rd_en", 32'(fb_rd_en), 32'(act_of(j)));
         check("fb_addr", 32'(fb_addr), 32'(addr_of(last_active(j))));
      end
      check("frame_swap_ack", 32'(ack), 32'(exp_ack));
      check("fb_sel", 32'(sel), 32'(fsel[(k / FT) % 256]));
      check("VGA_SYNC_N", 32'(syncn), 32'd0);
      // Default 640x480 instance: HS low for raster h 656..751, pixel (x=3,y=2) at index 1603.
      if (k == 658)  check("default HS before sync", 32'(d_hs), 32'd1);
      if (k == 659)  check("default HS falls at 656+3", 32'(d_hs), 32'd0);
      if (k == 754)  check("default HS last low clock", 32'(d_hs), 32'd0);
      if (k == 755)  check("default HS rises after 96", 32'(d_hs), 32'd1);
      if (k == 1604) check("default fb_addr of (3,2)", 32'(d_addr), 32'd321);
      if (k == 1606) check("default pixel_id of (3,2)", 32'(d_pix), 32'd1);
      if (k == 1606) check("default BLANK_N at (3,2)", 32'(d_blank), 32'd1);
   endtask

   always @(negedge clk) if (!rst) compare_cycle();

   // Period and width measurements taken from the DUT's own edges.
   bit prev_hs = 1'b1, prev_vs = 1'b1, prev_bl = 1'b0;
   int hs_fall = -1, vs_fall = -1, bl_rise = -1;
   bit m_hsper = 0, m_hslow = 0, m_vsper = 0, m_vslow = 0, m_blank = 0;

   task automatic measure();
      if (prev_hs && !hs) begin
         if (hs_fall >= 0 && !m_hsper) begin check("HS period", 32'(cyc - hs_fall), 32'(HT)); m_hsper = 1; end
         hs_fall = cyc;
      end
      if (!prev_hs && hs && hs_fall >= 0 && !m_hslow) begin
         check("HS low width", 32'(cyc - hs_fall), 32'(HSY)); m_hslow = 1;
      end
      if (prev_vs && !vs) begin
         if (vs_fall >= 0 && !m_vsper) begin check("VS period", 32'(cyc - vs_fall), 32'(FT)); m_vsper = 1; end
         vs_fall = cyc;
      end
      if (!prev_vs && vs && vs_fall >= 0 && !m_vslow) begin
         check("VS low width", 32'(cyc - vs_fall), 32'(VSY * HT)); m_vslow = 1;
      end
      if (!prev_bl && blank) bl_rise = cyc;
      if (prev_bl && !blank && bl_rise >= 0 && !m_blank) begin
         check("BLANK_N high width", 32'(cyc - bl_rise), 32'(HA)); m_blank = 1;
      end
      prev_hs = hs; prev_vs = vs; prev_bl = blank;
   endtask

   always @(negedge clk) if (!rst) measure();

   task automatic wait_phase(input int p);
      int n;
      n = 0;
      while ((cyc % FT) != p && n < 2 * FT) begin @(negedge clk); n++; end
      check("reached frame phase", 32'(cyc % FT), 32'(p));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " VGA_HS"}, 32'(hs), 32'd1);
      check({tag, " VGA_VS"}, 32'(vs), 32'd1);
      check({tag, " VGA_BLANK_N"}, 32'(blank), 32'd0);
      check({tag, " pixel_id"}, 32'(pix), 32'd0);
      check({tag, " fb_rd_en"}, 32'(fb_rd_en), 32'd0);
      check({tag, " fb_addr"}, 32'(fb_addr), 32'd0);
      check({tag, " frame_swap_ack"}, 32'(ack), 32'd0);
      check({tag, " fb_sel"}, 32'(sel), 32'd0);
   endtask

   initial begin
      int first_rise, acks, got;
      logic [2:0] sels;
      rst = 1'b1;
      req = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check_reset_values("reset");
      // Release just after an edge; counting that edge as the first, BLANK_N rises on the 4th.
      @(posedge clk);
      #1 rst = 1'b0;
      first_rise = -1;
      for (int n = 0; n < 10 && first_rise < 0; n++) begin
         @(negedge clk);
         if (blank) first_rise = cyc;
      end
      check("edges to first BLANK_N rise", 32'(first_rise), 32'd3);

      repeat (2000) begin
         @(negedge clk);
         if ($urandom_range(0, 149) == 0) req = !req;
      end
      req = 1'b0;
      repeat (FT) @(negedge clk);

      wait_phase(150);
      req = 1'b1;
      got = 0;
      for (int n = 0; n < 2 * FT && got == 0; n++) begin
         @(negedge clk);
         if (ack) got = 1;
      end
      check("swap ack seen", 32'(got), 32'd1);
      req = 1'b0;
      repeat (FT) @(negedge clk);

      wait_phase(100);
      req = 1'b1;
      repeat (50) @(negedge clk);
      req = 1'b0;
      acks = 0;
      repeat (2 * FT) begin
         @(negedge clk);
         if (ack) acks++;
      end
      check("cancelled request acks", 32'(acks), 32'd0);

      // Asynchronous reset in the middle of a line, checked before the next edge.
      repeat (37) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_reset_values("async reset");
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      wait_phase(150);
      req = 1'b1;
      acks = 0;
      sels = '0;
      for (int n = 0; n < 3 * FT; n++) begin
         @(negedge clk);
         if (ack) begin
            if (acks < 3) sels[acks] = sel;
            acks++;
         end
      end
      req = 1'b0;
      check("held request acks", 32'(acks), 32'd3);
      check("held request fb_sel sequence", 32'(sels), 32'b101);

      repeat (50) @(negedge clk);
      check("timing measurements observed",
            32'(int'(m_hsper) + int'(m_hslow) + int'(m_vsper) + int'(m_vslow) + int'(m_blank)), 32'd5);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
